byte_lane_arbiter: RTL and testbench

// - Shares one 8-bit byte lane between N_REQ requesters, each offering 32-bit words.
// - Round-robin grant; serializes the winning word MSB byte first, 4 lane cycles per word.
// - Marks word boundaries (sof/eof) so the downstream 8b->32b packer aligns on sof_out.
// - Sits between the transaction-layer word sources and the 8b->32b packer.

---
 rtl/byte_lane_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_byte_lane_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_arbiter.sv
// byte_lane_arbiter
//   Shares one 8-bit byte lane between N_REQ word sources. A round-robin
//   arbiter picks a requester. The winning 32-bit word is captured and sent
//   MSB byte first, one byte per cycle. sof_out and eof_out mark the word
//   boundaries for the downstream 8b->32b packer.
//
// Optional feature (macro BYTE_LANE_PARITY_EN):
//   Adds the parity_out port. It carries the even parity of data_out, is
//   registered with data_out and holds its value with data_out during hold.
//
// Ports:
//   clock      in   1          single clock, posedge
//   reset      in   1          asynchronous, active-high
//   req        in   N_REQ      req[i]: requester i holds a valid word
//   data_in    in   32*N_REQ   word of requester i at [32*i +: 32]
//   hold       in   1          lane back-pressure, 1 = freeze lane
//   ack        out  N_REQ      one-cycle pulse: word of requester i captured
//   data_out   out  8          current lane byte
//   valid_out  out  1          data_out carries a byte this cycle
//   sof_out    out  1          first byte of word (bits 31:24)
//   eof_out    out  1          last byte of word (bits 7:0)
//   src_out    out  ID_W       requester id of the word on the lane
//   busy       out  1          word in flight
//   parity_out out  1          ^data_out (only with BYTE_LANE_PARITY_EN)
module byte_lane_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  data_in,
  input  logic                 hold,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           data_out,
  output logic                 valid_out,
  output logic                 sof_out,
  output logic                 eof_out,
  output logic [ID_W-1:0]      src_out,
  output logic                 busy
`ifdef BYTE_LANE_PARITY_EN
  ,
  output logic                 parity_out
`endif
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;       // byte currently presented on the lane
  logic [31:0]       word_q, word_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic [ID_W-1:0]   src_q, src_d;

  // Round-robin search. Rotating req so that the pointer lands on bit 0
  // turns the search into a plain lowest-set-bit scan.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               found;
  int unsigned        offset;
  int unsigned        gnt_idx;
  logic [31:0]        win_word;
  logic               grant;
  logic [1:0]         idx_nxt;

  always_comb begin
    req_dbl  = {req, req} >> rr_q;
    req_rot  = req_dbl[N_REQ-1:0];
    found    = 1'b0;
    offset   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = k;
      end
    end
    gnt_idx  = (32'(rr_q) + offset) % N_REQ;
    win_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i == gnt_idx) win_word = data_in[32*i +: 32];
    end
  end

  // A new word may start only when no bytes are owed: idle, or eof on the lane.
  assign grant   = !hold && found && ((state_q == StIdle) || (idx_q == 2'd3));
  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    rr_d    = rr_q;
    ack_d   = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    src_d   = src_q;

    if (grant) begin
      word_d  = win_word;
      data_d  = win_word[31:24];
      src_d   = ID_W'(gnt_idx);
      valid_d = 1'b1;
      sof_d   = 1'b1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        ack_d[i] = (i == gnt_idx);
      end
      rr_d    = ID_W'((gnt_idx + 1) % N_REQ);
      state_d = StSend;
      idx_d   = 2'd0;
    end else if (!hold && (state_q == StSend)) begin
      if (idx_q == 2'd3) begin
        state_d = StIdle;
        idx_d   = 2'd0;
      end else begin
        idx_d   = idx_nxt;
        valid_d = 1'b1;
        eof_d   = (idx_nxt == 2'd3);
        unique case (idx_nxt)
          2'd1:    data_d = word_q[23:16];
          2'd2:    data_d = word_q[15:8];
          default: data_d = word_q[7:0];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      word_q  <= '0;
      rr_q    <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      src_q   <= src_d;
    end
  end

`ifdef BYTE_LANE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity_out = parity_q;
`endif

  assign ack       = ack_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sof_out   = sof_q;
  assign eof_out   = eof_q;
  assign src_out   = src_q;
  assign busy      = (state_q == StSend);

endmodule

// File: tb/tb_byte_lane_arbiter.sv
module tb_byte_lane_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [32*NREQ-1:0] data_in = '0;
  logic              hold = 1'b0;
  logic [NREQ-1:0]   ack;
  logic [7:0]        data_out;
  logic              valid_out, sof_out, eof_out, busy;
  logic [IDW-1:0]    src_out;
`ifdef BYTE_LANE_PARITY_EN
  logic              parity_out;
`endif

  byte_lane_arbiter #(.N_REQ(NREQ), .ID_W(IDW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .hold      (hold),
    .ack       (ack),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sof_out   (sof_out),
    .eof_out   (eof_out),
    .src_out   (src_out),
    .busy      (busy)
`ifdef BYTE_LANE_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [31:0] words[NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_words();
    for (int i = 0; i < NREQ; i++) data_in[32*i +: 32] = words[i];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ack"},   32'(ack), 0);
    chk({tag, " data"},  32'(data_out), 0);
    chk({tag, " valid"}, 32'(valid_out), 0);
    chk({tag, " sof"},   32'(sof_out), 0);
    chk({tag, " eof"},   32'(eof_out), 0);
    chk({tag, " src"},   32'(src_out), 0);
    chk({tag, " busy"},  32'(busy), 0);
  endtask

  // Reset asserted away from the edge; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    req  = '0;
    hold = 1'b0;
    reset = 1'b1;
    #2;
    check_zero(tag);
    step();
    reset = 1'b0;
  endtask

  // Directed vector table: inputs applied before an edge, outputs after it.
  typedef struct {
    logic [3:0] req;
    logic       hold;
    logic [3:0] ack;
    logic       valid;
    logic       sof;
    logic       eof;
    logic [7:0] data;
    logic [1:0] src;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(logic [3:0] r, logic h, logic [3:0] a, logic v, logic s,
                              logic e, logic [7:0] d, logic [1:0] sr, logic b);
    vec_t t;
    t.req = r; t.hold = h; t.ack = a; t.valid = v; t.sof = s; t.eof = e;
    t.data = d; t.src = sr; t.busy = b;
    return t;
  endfunction

  vec_t tbl[17];

  // Reference model: a queue of bytes still owed on the lane.
  logic [7:0]      owed[$];
  int unsigned     m_rr;
  logic [NREQ-1:0] m_ack;
  logic            m_valid, m_sof, m_eof, m_busy;
  logic [7:0]      m_data;
  logic [IDW-1:0]  m_src;

  task automatic model_reset();
    owed.delete();
    m_rr = 0; m_ack = '0; m_valid = 0; m_sof = 0; m_eof = 0; m_busy = 0;
    m_data = '0; m_src = '0;
  endtask

  task automatic model_edge();
    int unsigned w;
    bit          got;
    m_ack = '0; m_valid = 0; m_sof = 0; m_eof = 0;
    if (!hold) begin
      if (owed.size() == 0 && req != 0) begin
        got = 0;
        w   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (!got && req[(m_rr + k) % NREQ]) begin
            got = 1;
            w   = (m_rr + k) % NREQ;
          end
        end
        for (int b = 3; b >= 0; b--) owed.push_back(words[w][8*b +: 8]);
        m_ack[w] = 1'b1;
        m_src    = IDW'(w);
        m_rr     = (w + 1) % NREQ;
      end
      if (owed.size() > 0) begin
        m_sof   = (owed.size() == 4);
        m_eof   = (owed.size() == 1);
        m_data  = owed.pop_front();
        m_valid = 1;
        m_busy  = 1;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) words[i] = '0;
    drive_words();

    // Reset state
    #1;
    check_zero("por");
    step();
    step();
    reset = 1'b0;

    // Table: single word with a 3-cycle hold, then req1, then req0|req1
    words[0] = 32'hA1B2C3D4;
    words[1] = 32'h55667788;
    drive_words();
    tbl[0]  = mk(4'b0001, 0, 4'b0001, 1, 1, 0, 8'hA1, 2'd0, 1);
    tbl[1]  = mk(4'b0000, 0, 4'b0000, 1, 0, 0, 8'hB2, 2'd0, 1);
    tbl[2]  = mk(4'b0000, 1, 4'b0000, 0, 0, 0, 8'hB2, 2'd0, 1);
    tbl[3]  = mk(4'b0000, 1, 4'b0000, 0, 0, 0, 8'hB2, 2'd0, 1);
    tbl[4]  = mk(4'b0000, 1, 4'b0000, 0, 0, 0, 8'hB2, 2'd0, 1);
    tbl[5]  = mk(4'b0000, 0, 4'b0000, 1, 0, 0, 8'hC3, 2'd0, 1);
    tbl[6]  = mk(4'b0000, 0, 4'b0000, 1, 0, 1, 8'hD4, 2'd0, 1);
    tbl[7]  = mk(4'b0000, 0, 4'b0000, 0, 0, 0, 8'hD4, 2'd0, 0);
    tbl[8]  = mk(4'b0010, 0, 4'b0010, 1, 1, 0, 8'h55, 2'd1, 1);
    tbl[9]  = mk(4'b0011, 0, 4'b0000, 1, 0, 0, 8'h66, 2'd1, 1);
    tbl[10] = mk(4'b0011, 0, 4'b0000, 1, 0, 0, 8'h77, 2'd1, 1);
    tbl[11] = mk(4'b0011, 0, 4'b0000, 1, 0, 1, 8'h88, 2'd1, 1);
    tbl[12] = mk(4'b0011, 0, 4'b0001, 1, 1, 0, 8'hA1, 2'd0, 1);
    tbl[13] = mk(4'b0011, 0, 4'b0000, 1, 0, 0, 8'hB2, 2'd0, 1);
    tbl[14] = mk(4'b0011, 0, 4'b0000, 1, 0, 0, 8'hC3, 2'd0, 1);
    tbl[15] = mk(4'b0011, 0, 4'b0000, 1, 0, 1, 8'hD4, 2'd0, 1);
    tbl[16] = mk(4'b0011, 0, 4'b0010, 1, 1, 0, 8'h55, 2'd1, 1);
    for (int i = 0; i < 17; i++) begin
      req  = tbl[i].req;
      hold = tbl[i].hold;
      step();
      chk($sformatf("vec%0d ack", i),   32'(ack),       32'(tbl[i].ack));
      chk($sformatf("vec%0d valid", i), 32'(valid_out), 32'(tbl[i].valid));
      chk($sformatf("vec%0d sof", i),   32'(sof_out),   32'(tbl[i].sof));
      chk($sformatf("vec%0d eof", i),   32'(eof_out),   32'(tbl[i].eof));
      chk($sformatf("vec%0d data", i),  32'(data_out),  32'(tbl[i].data));
      chk($sformatf("vec%0d src", i),   32'(src_out),   32'(tbl[i].src));
      chk($sformatf("vec%0d busy", i),  32'(busy),      32'(tbl[i].busy));
    end

    // All requesters active: strict rotation with no bubble
    do_reset("rst_all");
    for (int i = 0; i < NREQ; i++) words[i] = 32'h11111111 * (i + 1);
    drive_words();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("all c%0d valid", c), 32'(valid_out), 1);
      chk($sformatf("all c%0d src", c),   32'(src_out), (c / 4) % 4);
      chk($sformatf("all c%0d data", c),  32'(data_out), 32'h11 * ((c / 4) % 4 + 1));
      chk($sformatf("all c%0d sof", c),   32'(sof_out), 32'(c % 4 == 0));
      chk($sformatf("all c%0d ack", c),   32'(ack),
          (c % 4 == 0) ? (32'd1 << ((c / 4) % 4)) : 32'd0);
    end

    // Reset in the middle of a word, then a fresh word from requester 0
    do_reset("rst_mid0");
    words[0] = 32'hA1B2C3D4;
    drive_words();
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    chk("mid pre data", 32'(data_out), 32'hB2);
    do_reset("rst_mid");
    req = 4'b0001;
    step();
    chk("mid fresh sof",  32'(sof_out), 1);
    chk("mid fresh data", 32'(data_out), 32'hA1);
    chk("mid fresh ack",  32'(ack), 32'b0001);
    req = 4'b0000;
    step(); step(); step();
    chk("mid fresh eof",  32'(eof_out), 1);
    chk("mid fresh last", 32'(data_out), 32'hD4);

`ifdef BYTE_LANE_PARITY_EN
    do_reset("rst_par");
    chk("par reset", 32'(parity_out), 0);
    words[0] = 32'h01030700;
    drive_words();
    req = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      step();
      req = 4'b0000;
      chk($sformatf("par b%0d", b), 32'(parity_out), 32'(b % 2 == 0));
    end
`endif

    // Randomized traffic against the owed-byte queue model
    do_reset("rst_rand");
    model_reset();
    for (int i = 0; i < NREQ; i++) words[i] = $urandom;
    drive_words();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_ack[i]) begin
          req[i] = ($urandom_range(0, 1) == 0);
          words[i] = $urandom;
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i]   = 1'b1;
          words[i] = $urandom;
        end
      end
      drive_words();
      hold = ($urandom_range(0, 4) == 0);
      model_edge();
      step();
      chk($sformatf("rnd%0d ack", c),   32'(ack),       32'(m_ack));
      chk($sformatf("rnd%0d valid", c), 32'(valid_out), 32'(m_valid));
      chk($sformatf("rnd%0d sof", c),   32'(sof_out),   32'(m_sof));
      chk($sformatf("rnd%0d eof", c),   32'(eof_out),   32'(m_eof));
      chk($sformatf("rnd%0d data", c),  32'(data_out),  32'(m_data));
      chk($sformatf("rnd%0d src", c),   32'(src_out),   32'(m_src));
      chk($sformatf("rnd%0d busy", c),  32'(busy),      32'(m_busy));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
